// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: slave select, serial clock generation and
// shift/sample strobes for one 8-bit transfer in any of the four SPI modes.
module spi_xfer_ctrl #(
  parameter int unsigned SETUP_CYC = 2
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic [2:0] sppr_i,
  input  logic [2:0] spr_i,
  output logic       ss_o,
  output logic       sclk_o,
  output logic       send_data_o,
  output logic       rec_data_o,
  output logic       mosi_s_sclk_o,
  output logic       mosi_s_sclk0_o,
  output logic       miso_r_sclk_o,
  output logic       miso_r_sclk0_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] bit_cnt_o
);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StDone} state_e;

  localparam logic [11:0] SetupLast = 12'(SETUP_CYC - 1);

  state_e      state_q, state_d;
  logic        cpol_q, cpha_q;
  logic [2:0]  sppr_q, spr_q;
  logic [11:0] baud_q, baud_d;
  logic [4:0]  tog_q, tog_d;
  logic [3:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic        send_q, send_d;

  logic [11:0] half_m1;
  logic [4:0]  tog_num;
  logic        accept, edge_hit, leading, shift_ev, sample_ev, route0;

  // Half-period in pclk cycles is (sppr+1) * 2^spr.
  assign half_m1  = (({9'd0, sppr_q} + 12'd1) << spr_q) - 12'd1;
  assign accept   = (state_q == StIdle) && start_i && !abort_i;
  assign edge_hit = (state_q == StXfer) && (baud_q == half_m1);
  assign tog_num  = tog_q + 5'd1;
  assign leading  = tog_num[0];
  assign route0   = cpol_q ^ cpha_q;

  always_comb begin
    shift_ev  = 1'b0;
    sample_ev = 1'b0;
    // cpha=0 needs the first bit on the line before the first sclk edge.
    if (state_q == StSetup && baud_q == SetupLast && !cpha_q) begin
      shift_ev = 1'b1;
    end
    if (edge_hit) begin
      if (!cpha_q) begin
        sample_ev = leading;
        shift_ev  = !leading && (tog_num != 5'd16);
      end else begin
        shift_ev  = leading;
        sample_ev = !leading;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    tog_d   = tog_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    send_d  = 1'b0;
    if (sample_ev && bit_q != 4'd8) begin
      bit_d = bit_q + 4'd1;
    end
    unique case (state_q)
      StIdle: begin
        sclk_d = cpol_i;
        if (accept) begin
          state_d = StSetup;
          send_d  = 1'b1;
          baud_d  = '0;
          tog_d   = '0;
          bit_d   = '0;
        end
      end
      StSetup: begin
        sclk_d = cpol_q;
        if (baud_q == SetupLast) begin
          state_d = StXfer;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      StXfer: begin
        if (edge_hit) begin
          baud_d = '0;
          sclk_d = ~sclk_q;
          tog_d  = tog_q + 5'd1;
          if (tog_q == 5'd15) begin
            state_d = StDone;
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        sclk_d  = cpol_i;
      end
    endcase
    if (abort_i && state_q != StIdle) begin
      state_d = StIdle;
      sclk_d  = cpol_i;
      baud_d  = '0;
      tog_d   = '0;
      bit_d   = '0;
      send_d  = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      tog_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      send_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sppr_q  <= '0;
      spr_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      tog_q   <= tog_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      send_q  <= send_d;
      if (accept) begin
        cpol_q <= cpol_i;
        cpha_q <= cpha_i;
        sppr_q <= sppr_i;
        spr_q  <= spr_i;
      end
    end
  end

  assign ss_o           = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign sclk_o         = sclk_q;
  assign send_data_o    = send_q;
  assign done_o         = (state_q == StDone) && !abort_i;
  assign rec_data_o     = (state_q == StDone) && !abort_i;
  assign mosi_s_sclk_o  = shift_ev && !route0;
  assign mosi_s_sclk0_o = shift_ev && route0;
  assign miso_r_sclk_o  = sample_ev && !route0;
  assign miso_r_sclk0_o = sample_ev && route0;
  assign bit_cnt_o      = bit_q;

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: pclk cycles from ss_o fall to start of first sclk half-period (range 1..15).
REQ-002 SHALL have port pclk  in  1  clock.
REQ-003 SHALL have port preset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port start_i  in  1  transfer request, level-sampled in IDLE only.
REQ-005 SHALL have port abort_i  in  1  synchronous transfer cancel.
REQ-006 SHALL have ports cpol_i, cpha_i  in  1 each  SPI mode.
REQ-007 SHALL have ports sppr_i, spr_i  in  3 each  baud select.
REQ-008 SHALL have ports ss_o (slave select, active low) and sclk_o (serial clock)  out  1 each.
REQ-009 SHALL have ports send_data_o and rec_data_o  out  1 each  load-TX-byte and RX-byte-valid pulses to the shift register.
REQ-010 SHALL have ports mosi_s_sclk_o, mosi_s_sclk0_o, miso_r_sclk_o, miso_r_sclk0_o  out  1 each  shift/sample strobes.
REQ-011 SHALL have ports busy_o, done_o  out  1 each; bit_cnt_o  out  4  completed sample count 0..8.

Function
REQ-012 Divisor SHALL be D = (sppr_i+1) * 2^(spr_i+1) (2..2048); half-period H = D/2 pclk cycles; 12-bit baud counter.
REQ-013 cpol_i, cpha_i, sppr_i, spr_i SHALL be latched on start acceptance; changes mid-transfer ignored.
REQ-014 FSM states SHALL be IDLE, SETUP, XFER, DONE; busy_o = 1 in all but IDLE.
REQ-015 IDLE: ss_o=1, sclk_o=cpol_i (live), all strobes 0; start_i=1 at cycle t -> send_data_o=1 at t+1 (single cycle), ss_o=0 from t+1, state SETUP.
REQ-016 SETUP SHALL last SETUP_CYC cycles then enter XFER; if cpha=0 one shift strobe SHALL pulse in the last SETUP cycle.
REQ-017 XFER: baud counter counts 0..H-1; at H-1 sclk_o toggles on next pclk edge; exactly 16 toggles per transfer; sclk_o ends at cpol.
REQ-018 Edge strobes SHALL pulse 1 cycle, in the cycle the counter is at H-1 (concurrent with the registering of the sclk toggle).
REQ-019 cpha=0: sample strobe on leading (odd) toggles 1,3..15; shift strobe on trailing toggles 2..14 (toggle 16 suppressed). cpha=1: shift strobe on leading toggles, sample strobe on trailing toggles.
REQ-020 Routing: cpol==cpha -> strobes on mosi_s_sclk_o / miso_r_sclk_o, *_sclk0_o held 0; cpol!=cpha -> strobes on *_sclk0_o, others held 0.
REQ-021 Exactly 8 shift and 8 sample strobes SHALL occur per completed transfer.
REQ-022 bit_cnt_o SHALL clear on start acceptance and increment per sample strobe, saturating at 8.
REQ-023 After toggle 16 -> DONE for one cycle: rec_data_o=1, done_o=1 (single cycle), ss_o still 0; next cycle IDLE, ss_o=1.
REQ-024 Total transfer SHALL be 1 + SETUP_CYC + 8*D + 1 cycles from start acceptance to ss_o rise.
REQ-025 start_i while busy_o=1 SHALL be ignored (not queued).
REQ-026 abort_i=1 in any non-IDLE state -> IDLE next cycle: ss_o=1, sclk_o=cpol, counters cleared, no done_o/rec_data_o pulse; abort_i has priority over start_i.
REQ-027 start_i held high through DONE SHALL start a new transfer from IDLE one cycle later (back-to-back allowed).

Reset
REQ-028 preset_n=0 SHALL asynchronously force IDLE, ss_o=1, sclk_o=0, all strobes/pulses 0, busy_o=0, bit_cnt_o=0, counters and latched config 0.
REQ-029 First sclk_o after reset release SHALL follow cpol_i within one cycle.
REQ-030 Reset mid-transfer SHALL abort without done_o/rec_data_o.

Verification
REQ-031 Mode 0, sppr=0 spr=0 (D=2), start pulse -> send_data 1 cycle, 16 sclk toggles 1 cycle apart, 8 miso_r_sclk_o + 8 mosi_s_sclk_o pulses (1 in SETUP), done_o at 1+2+16+1=20, bit_cnt_o=8.
REQ-032 Mode 1 and mode 3, sppr=1 spr=1 (D=8) -> mode 1 strobes only on *_sclk0_o, mode 3 only on non-0 outputs; sclk half-period 4 cycles; idle level 0/1 respectively.
REQ-033 sppr=7 spr=7 -> D=2048, H=1024 measured between sclk toggles; transfer length 2+2+16384 cycles.
REQ-034 Abort after 3rd sample strobe -> ss_o=1 next cycle, no done_o/rec_data_o; fresh start then completes normally with bit_cnt_o 0..8.
REQ-035 start_i pulsed during XFER -> ignored, single done_o; preset_n low mid-XFER -> ss_o=1, sclk_o=0 immediately.
